mult_pipe_wrapper: RTL
======================

# mult_pipe_wrapper

Parametrised, pipelined integer multiplier wrapper with valid/ready flow control and a per-transaction signed/unsigned mode. It is the next generation of the fixed 32-bit register-in/register-out multiplier wrappers: width and pipeline depth are configurable, and backpressure stalls the pipeline without dropping or duplicating results. It sits between a streaming operand source and a result consumer and also serves as the standard PPA harness for multiplier sweeps.

## Interface
- WIDTH, default 32: operand width in bits, at least 4.
- STAGES, default 3: total register stages from operand capture to `out_product`, at least 2.
- TAG_W, default 8: tag width; used only when `MULT_PIPE_TAG_EN` is defined.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  wrapper can accept the pair this cycle.
- in_signed  in  1  1 = both operands are two's complement; 0 = both unsigned.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- out_valid  out  1  `out_product` holds a result.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*WIDTH  full-width product.
- busy  out  1  OR of all stage valid bits.
- in_tag / out_tag  in/out  TAG_W  present only with `MULT_PIPE_TAG_EN`.

## Operation
- Accept on `in_valid && in_ready`. Complete on `out_valid && out_ready`.
- Stage 1 registers the operands and `in_signed`. The product is formed combinationally from the stage-1 registers. Stages 2..STAGES carry the product. Every stage has its own valid bit.
- Product arithmetic:
  - Signed: sign-extend both operands to 2*WIDTH and take the low 2*WIDTH bits of the product.
  - Unsigned: zero-extend both operands.
  - The result is exact in both modes, including (-2^(W-1))² = 2^(2W-2).
- Bubble-collapsing stall rule:
  - Stage k loads when it is empty or when stage k+1 loads.
  - The last stage loads when it is empty or `out_ready` = 1.
  - `in_ready` = stage 1 loads.
  - `in_ready` may depend combinationally on `out_ready`.
- A stage that loads from an empty predecessor clears its valid bit.
- A stalled stage holds both its data and its valid bit.
- `out_valid` is the valid bit of the last stage. `out_product` is that stage's data.
- No reordering, no drops, no duplicates. Results leave in acceptance order.

## Timing
- Latency: a pair accepted at edge N produces `out_valid` = 1 after edge N+STAGES-1, when there is no stall.
- Throughput: one result per cycle while `out_ready` = 1.
- Capacity: STAGES results in flight. With `out_ready` held at 0, exactly STAGES pairs are accepted, then `in_ready` drops to 0.
- While `out_valid && !out_ready`, `out_product` (and `out_tag`) hold stable.
- Simultaneous accept and complete on a full pipeline is allowed. `in_ready` = 1 in that cycle, and occupancy is unchanged.
- Reset values: all valid bits = 0, `out_valid` = 0, `out_product` = 0, `busy` = 0, `out_tag` = 0. `in_ready` = 1 from the first cycle after reset.
- Data registers outside the last stage are not reset.
- Reset mid-operation discards every in-flight result. No `out_valid` appears for pairs accepted before the reset.
- `in_valid` while `rst` = 1 is ignored.

## Configuration
- `MULT_PIPE_TAG_EN`:
  - Defined: `in_tag` is captured with the operands and travels with the valid bits. `out_tag` equals the tag of the pair whose product is on `out_product`.
  - Undefined: `in_tag`, `out_tag` and the tag registers are absent. Operation and timing are otherwise identical.

## Test plan
All scenarios use WIDTH=32 unless stated.
- Single transaction: STAGES=3, `out_ready`=1, signed, 0xFFFFFFFF × 0xFFFFFFFF → `out_product` 0x0000000000000001, with `out_valid` 2 cycles after accept.
- Mode sweep:
  - Unsigned 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001.
  - Signed 0x80000000 × 0x7FFFFFFF → 0xC000000080000000.
  - Signed 0x80000000 × 0x80000000 → 0x4000000000000000.
- Backpressure: STAGES=4, `out_ready`=0, `in_valid` held high → exactly 4 accepts, then `in_ready`=0. Release `out_ready` → 4 results in order, the first held stable throughout the stall.
- Random stall: 1000 random operand/mode pairs, `in_valid` and `out_ready` each 50% random → all results match a 64-bit reference model in order, none lost or duplicated, `busy` low at the end.
- Reset mid-flight: 3 pairs in flight, assert `rst` for 1 cycle → `out_valid` stays 0 and `out_product` reads 0. The next accepted pair 3 × 5 → 15.
- Tag build (`MULT_PIPE_TAG_EN`, WIDTH=8, STAGES=2): tags 0x01..0x10 with random stalls → `out_tag` sequence 0x01..0x10, each paired with the correct product.

Source files
------------

// File: rtl/mult_pipe_wrapper.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready flow control, per-pair signed mode
// and bubble-collapsing stalls. Optional tag sideband enabled by defining MULT_PIPE_TAG_EN.
module mult_pipe_wrapper #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
`ifdef MULT_PIPE_TAG_EN
    ,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag
`endif
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] load_s;
    logic              full_s;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  a_d;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  b_d;
    logic              sgn_q;
    logic              sgn_d;
    logic [PW-1:0]     ext_a_s;
    logic [PW-1:0]     ext_b_s;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     data_q [1:STAGES-1];
    logic [PW-1:0]     data_d [1:STAGES-1];
    logic [PW-1:0]     feed_s [1:STAGES-1];

    // Out-of-range parameters leave this empty marker block in the hierarchy.
    if (WIDTH < 4 || STAGES < 2 || TAG_W < 1) begin : g_bad_params
    end

    // Load enables: a stage loads unless it and every stage after it is full while the consumer stalls.
    always_comb begin
        load_s = '0;
        full_s = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            full_s = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full_s = full_s & vld_q[j];
            end
            load_s[k] = out_ready | ~full_s;
        end
    end

    // Product of the captured operands; sign- or zero-extend, then keep the low 2*WIDTH bits.
    always_comb begin
        if (sgn_q) begin
            ext_a_s = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            ext_b_s = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            ext_a_s = {{WIDTH{1'b0}}, a_q};
            ext_b_s = {{WIDTH{1'b0}}, b_q};
        end
        prod_s = ext_a_s * ext_b_s;
    end

    // Data feeding each product stage: the multiplier for stage 2, the previous stage otherwise.
    always_comb begin
        feed_s[1] = prod_s;
        for (int k = 2; k < STAGES; k++) begin
            feed_s[k] = data_q[k-1];
        end
    end

    // Next-state for valid bits and stage data; data only moves when the source stage holds a result.
    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        sgn_d  = sgn_q;
        data_d = data_q;
        if (load_s[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                a_d   = multiplicand;
                b_d   = multiplier;
                sgn_d = in_signed;
            end else begin
                a_d   = a_q;
                b_d   = b_q;
                sgn_d = sgn_q;
            end
        end else begin
            vld_d[0] = vld_q[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load_s[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = feed_s[k];
                end else begin
                    data_d[k] = data_q[k];
                end
            end else begin
                vld_d[k] = vld_q[k];
            end
        end
    end

    // Pipeline registers; only valid bits and the output stage data are cleared by reset.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        sgn_q  <= sgn_d;
        data_q <= data_d;
        if (rst) begin
            vld_q            <= '0;
            data_q[STAGES-1] <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign in_ready    = load_s[0];
    assign out_valid   = vld_q[STAGES-1];
    assign out_product = data_q[STAGES-1];
    assign busy        = |vld_q;

`ifdef MULT_PIPE_TAG_EN
    logic [TAG_W-1:0] tag_q [STAGES];
    logic [TAG_W-1:0] tag_d [STAGES];

    // Tags follow exactly the same load decisions as the valid bits.
    always_comb begin
        tag_d = tag_q;
        if (load_s[0] && in_valid) begin
            tag_d[0] = in_tag;
        end else begin
            tag_d[0] = tag_q[0];
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load_s[k] && vld_q[k-1]) begin
                tag_d[k] = tag_q[k-1];
            end else begin
                tag_d[k] = tag_q[k];
            end
        end
    end

    // Tag registers; only the output stage tag is cleared by reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (rst) begin
            tag_q[STAGES-1] <= '0;
        end else begin
            tag_q[STAGES-1] <= tag_d[STAGES-1];
        end
    end

    assign out_tag = tag_q[STAGES-1];
`endif

endmodule
